// File: rtl/scaled_video_timing_gen_if.sv
// Pixel FIFO read port and video output bundle for scaled_video_timing_gen.
// The timing generator drives the video side through the master modport.
interface scaled_video_timing_gen_if;
    logic [15:0] pixel_data;
    logic        fifo_empty;
    logic        rd_enable;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [23:0] rgb_data;
    logic        frame_start;
    logic        underflow;

    modport master (
        input  pixel_data, fifo_empty,
        output rd_enable, hsync, vsync, de, rgb_data, frame_start, underflow
    );

    modport slave (
        output pixel_data, fifo_empty,
        input  rd_enable, hsync, vsync, de, rgb_data, frame_start, underflow
    );
endinterface

// File: rtl/scaled_video_timing_gen.sv
// Video timing generator with integer pixel/line upscaling from a FWFT pixel FIFO.
// Fetch lines pop the FIFO and fill a line buffer; repeat lines replay the buffer.
module scaled_video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SCALE    = 2,
    parameter int IN_FMT   = 0,
    parameter int SYNC_POL = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    scaled_video_timing_gen_if.master  bus
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW        = $clog2(H_TOTAL + 1);
    localparam int VW        = $clog2(V_TOTAL + 1);
    localparam int BUF_DEPTH = H_ACTIVE / SCALE;
    localparam int BW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int SHIFT     = (SCALE == 4) ? 2 : ((SCALE == 2) ? 1 : 0);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_ON_C  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_OFF_C = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_MASK_C = HW'(SCALE - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_ON_C  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_OFF_C = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_MASK_C = VW'(SCALE - 1);
    localparam logic          SYNC_ON  = (SYNC_POL != 0);

    if (!(SCALE == 1 || SCALE == 2 || SCALE == 4) ||
        (H_ACTIVE % SCALE != 0) || (V_ACTIVE % SCALE != 0)) begin : g_bad_cfg
        $error("scaled_video_timing_gen: SCALE must be 1, 2 or 4 and divide H_ACTIVE and V_ACTIVE");
    end

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          r_state;
    logic [HW-1:0]   r_h_cnt;
    logic [VW-1:0]   r_v_cnt;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_de;
    logic [23:0]     r_rgb;
    logic            r_frame_start;
    logic            r_underflow;
    logic [15:0]     r_line_buf [BUF_DEPTH];

    logic            w_go;
    logic            w_active;
    logic            w_fetch;
    logic            w_last_phase;
    logic            w_hs_act;
    logic            w_vs_act;
    logic            w_first_px;
    logic            w_uf_new;
    logic [BW-1:0]   w_idx;
    logic [15:0]     w_fifo_px;
    logic [15:0]     w_src;

    function automatic logic [23:0] expand(input logic [15:0] px);
        return (IN_FMT == 0)
            ? {px[11:8], px[11:8], px[7:4], px[7:4], px[3:0], px[3:0]}
            : {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
    endfunction

    // Pops and buffer writes only happen on cycles whose pixel will actually be displayed.
    always_comb begin
        w_go         = (r_state == RUN) && en && !rst;
        w_active     = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
        w_fetch      = ((r_v_cnt & V_MASK_C) == '0);
        w_last_phase = ((r_h_cnt & H_MASK_C) == H_MASK_C);
        w_hs_act     = (r_h_cnt >= HS_ON_C) && (r_h_cnt < HS_OFF_C);
        w_vs_act     = (r_v_cnt >= VS_ON_C) && (r_v_cnt < VS_OFF_C);
        w_first_px   = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_idx        = BW'(r_h_cnt >> SHIFT);
        w_fifo_px    = bus.fifo_empty ? 16'h0000 : bus.pixel_data;
        w_src        = w_fetch ? w_fifo_px : r_line_buf[w_idx];
        w_uf_new     = w_active && w_fetch && bus.fifo_empty;
    end

    assign bus.rd_enable = w_go && w_active && w_fetch && w_last_phase;

    always_ff @(posedge clk) begin
        if (bus.rd_enable) begin
            r_line_buf[w_idx] <= w_fifo_px;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= ~SYNC_ON;
            r_vsync       <= ~SYNC_ON;
            r_de          <= 1'b0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= ~SYNC_ON;
            r_vsync       <= ~SYNC_ON;
            r_de          <= 1'b0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        r_state <= IDLE;
                    end else begin
                        r_hsync       <= w_hs_act ? SYNC_ON : ~SYNC_ON;
                        r_vsync       <= w_vs_act ? SYNC_ON : ~SYNC_ON;
                        r_de          <= w_active;
                        r_rgb         <= w_active ? expand(w_src) : 24'h000000;
                        r_frame_start <= w_first_px;
                        // A fresh underflow on the first pixel outranks the frame-start clear.
                        r_underflow   <= w_uf_new || (r_underflow && !w_first_px);
                        if (r_h_cnt == H_LAST_C) begin
                            r_h_cnt <= '0;
                            r_v_cnt <= (r_v_cnt == V_LAST_C) ? '0 : r_v_cnt + 1'b1;
                        end else begin
                            r_h_cnt <= r_h_cnt + 1'b1;
                            r_v_cnt <= r_v_cnt;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.de          = r_de;
    assign bus.rgb_data    = r_rgb;
    assign bus.frame_start = r_frame_start;
    assign bus.underflow   = r_underflow;
endmodule

// File: doc/scaled_video_timing_gen.md
SCALED_VIDEO_TIMING_GEN -- requirements
Module: scaled_video_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width
- SCALE, 2, integer upscale factor; legal values 1, 2, 4
- IN_FMT, 0, pixel format: 0 = RGB444 in [11:0], 1 = RGB565
- SYNC_POL, 0, sync polarity: 0 = active-low, 1 = active-high
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; low = idle
- pixel_data  in  16  first-word-fall-through FIFO head word
- fifo_empty  in  1  FIFO empty flag
- rd_enable  out  1  FIFO pop strobe
- hsync, vsync  out  1 each  sync outputs
- de  out  1  data enable
- rgb_data  out  24  R[23:16] G[15:8] B[7:0]
- frame_start  out  1  one-cycle pulse at the first active pixel of each frame
- underflow  out  1  sticky FIFO-underflow flag
REQ-003 The block SHALL have one clock, clk; reset SHALL be rst, synchronous and active-high.

Function
REQ-004 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL be the vertical equivalent; h_cnt SHALL count 0..H_TOTAL-1.
REQ-005 v_cnt SHALL increment when h_cnt wraps, and SHALL wrap to 0 after V_TOTAL-1.
REQ-006 The state machine SHALL have states IDLE and RUN.
- IDLE -> RUN when en=1; first RUN cycle has h_cnt=v_cnt=0.
- RUN -> IDLE on the cycle after en=0; the counters clear.
REQ-007 Raw signals SHALL be derived from the counters (active-low case; SYNC_POL=1 inverts).
- hsync: active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
- vsync: active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC
- active: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE
REQ-008 hsync, vsync, de, rgb_data and frame_start SHALL all be registered with exactly 1 cycle latency from counter state, so they are mutually aligned.
REQ-009 A fetch line SHALL be any active line with v_cnt mod SCALE = 0; all other active lines SHALL be repeat lines.
REQ-010 rd_enable SHALL be combinational and SHALL equal active AND fetch line AND (h_cnt mod SCALE = SCALE-1), giving H_ACTIVE/SCALE pops per fetch line.
REQ-011 On fetch lines, the displayed source pixel SHALL be pixel_data.
REQ-012 On every rd_enable cycle, pixel_data SHALL also be written to line_buffer[h_cnt/SCALE].
- Buffer depth SHALL be H_ACTIVE/SCALE words of 16 bits.
REQ-013 On repeat lines, the source pixel SHALL be line_buffer[h_cnt/SCALE].
REQ-014 Colour expansion SHALL be by MSB replication.
- RGB444: 8-bit channel = {c4,c4}
- RGB565: R and B = {c5,c5[4:2]}, G = {c6,c6[5:4]}
REQ-015 When active=0, rgb_data SHALL be 0.
REQ-016 If a fetch-line pixel is displayed while fifo_empty=1, that pixel SHALL be output as 0.
- The value written to the line buffer SHALL also be 0.
- underflow SHALL be set.
- rd_enable SHALL still follow REQ-010, because the FIFO ignores pops while empty.
REQ-017 underflow SHALL clear only on a frame_start cycle with no new underflow, or on rst; if set and cleared in the same cycle, set SHALL win.
REQ-018 frame_start SHALL be asserted, aligned with de, for the pixel with h_cnt=0, v_cnt=0.
REQ-019 Illegal SCALE values, or H_ACTIVE or V_ACTIVE not divisible by SCALE, SHALL fail elaboration.

Reset
REQ-020 While rst=1 on a clk edge, the block SHALL take these values on that edge:
- state=IDLE, h_cnt=v_cnt=0
- de=0, rgb_data=0, frame_start=0, underflow=0
- hsync and vsync at their inactive levels
- rd_enable=0
REQ-021 Reset asserted mid-frame SHALL take effect on the next edge; line buffer contents SHALL NOT be cleared.
REQ-022 In IDLE, outputs SHALL hold the reset values.

Verification
REQ-023 Defaults, en=1, FIFO holding an incrementing pattern -> de high 640 cycles per line for 480 lines; hsync low 96 cycles starting at h_cnt=656; vsync low for lines 490-491; frame period 420000 cycles.
REQ-024 SCALE=2 -> 320 pops on each even active line and 0 on odd lines; line 1 rgb_data equals line 0 rgb_data cycle-for-cycle; each source pixel appears twice horizontally.
REQ-025 SCALE=4, RGB565 pixel 16'hF800 -> rgb_data 24'hFF0000 in a 4x4 block; RGB444 12'h0F0 -> 24'h00FF00.
REQ-026 fifo_empty=1 for 3 pops on line 0 -> those pixels and their line-1 repeats are 0; underflow is set; underflow clears at the next frame_start when the FIFO is healthy.
REQ-027 rst pulse at h_cnt=300, v_cnt=100 -> all outputs take reset values on the next edge; restart at h_cnt=0, v_cnt=0 with frame_start after 1 cycle.
REQ-028 en dropped mid-line -> IDLE and outputs inactive within 1 cycle; en raised again -> frame_start exactly 1 cycle after the RUN entry.
